// File: rtl/pc_rd.sv
// pc_rd: strided read-request generator with a credit-limited response FIFO
// and a beat-to-word serializer feeding the PE array input column.
module pc_rd #(
  parameter int WIDTH_ARR   = 16,
  parameter int WIDTH_BUS   = 64,
  parameter int P_ID        = 0,
  parameter int nRows       = 3,
  parameter int MAX_nPERIOD = 16,
  parameter int MAX_nCHN    = 2048,
  parameter int FIFO_DEPTH  = 4,
  localparam int WIDTH_P_ID       = 6,
  localparam int WIDTH_MEM_ADDR   = 28,
  localparam int WP               = $clog2(MAX_nPERIOD),
  localparam int WC               = $clog2(MAX_nCHN),
  localparam int WIDTH_CONFIGBITS = 3*WIDTH_MEM_ADDR + WP + WC
) (
  input  logic                              clk_array,
  input  logic                              rst_array,
  input  logic                              start,
  input  logic [WIDTH_CONFIGBITS-1:0]       config_bits,
  input  logic                              tk_en,
  output logic [33:0]                       rd_req_out,
  output logic                              rd_req_en,
  input  logic [WIDTH_P_ID+WIDTH_BUS-1:0]   rd_resp_in,
  input  logic                              rd_resp_en,
  input  logic                              arr_rdy,
  output logic [WIDTH_ARR-1:0]              data_pc2arr,
  output logic                              data_pc2arr_en,
  output logic                              busy,
  output logic                              done,
  output logic                              ovf_err
);

  localparam int R   = WIDTH_BUS / WIDTH_ARR;
  localparam int RW  = (nRows > 1) ? $clog2(nRows) : 1;
  localparam int TW  = $clog2(nRows*MAX_nCHN*MAX_nPERIOD + 1);
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int PW  = AW + 1;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int WLW = $clog2(R + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]                state_q, state_d;
  logic [WIDTH_MEM_ADDR-1:0] base_q, base_d, cstr_q, cstr_d, rstr_q, rstr_d;
  logic [WP-1:0]             nper_q, nper_d, col_q, col_d;
  logic [WC-1:0]             nchn_q, nchn_d, chn_q, chn_d;
  logic [RW-1:0]             row_q, row_d;
  logic [TW-1:0]             total_q, total_d, rx_cnt_q, rx_cnt_d;
  logic [CW-1:0]             credits_q, credits_d;
  logic [PW-1:0]             wptr_q, wptr_d, rptr_q, rptr_d;
  logic [WIDTH_BUS-1:0]      sreg_q, sreg_d;
  logic [WLW-1:0]            wleft_q, wleft_d;
  logic [WIDTH_ARR-1:0]      dout_q, dout_d;
  logic                      dout_en_q, dout_en_d;
  logic                      done_q, done_d;
  logic                      ovf_q, ovf_d;
  logic [WIDTH_BUS-1:0]      fifo_mem_q [FIFO_DEPTH];

  // Configuration field split and zero-means-one normalisation
  logic [WIDTH_MEM_ADDR-1:0] cfg_base, cfg_cstr, cfg_rstr;
  logic [WP-1:0]             cfg_nper, cfg_nper_eff;
  logic [WC-1:0]             cfg_nchn, cfg_nchn_eff;

  assign cfg_base     = config_bits[WIDTH_CONFIGBITS-1 -: WIDTH_MEM_ADDR];
  assign cfg_cstr     = config_bits[WP+WC+2*WIDTH_MEM_ADDR-1 -: WIDTH_MEM_ADDR];
  assign cfg_rstr     = config_bits[WP+WC+WIDTH_MEM_ADDR-1 -: WIDTH_MEM_ADDR];
  assign cfg_nper     = config_bits[WC +: WP];
  assign cfg_nchn     = config_bits[0 +: WC];
  assign cfg_nper_eff = (cfg_nper == '0) ? WP'(1) : cfg_nper;
  assign cfg_nchn_eff = (cfg_nchn == '0) ? WC'(1) : cfg_nchn;

  logic [WIDTH_P_ID-1:0]     resp_id;
  logic [WIDTH_BUS-1:0]      resp_data;
  logic                      id_match, fifo_empty, fifo_full, push, pop;
  logic                      req_en, accept, emit;
  logic                      row_last, chn_last, col_last;
  logic [WIDTH_MEM_ADDR-1:0] mem_r_addr;

  assign resp_id    = rd_resp_in[WIDTH_BUS +: WIDTH_P_ID];
  assign resp_data  = rd_resp_in[WIDTH_BUS-1:0];
  assign id_match   = rd_resp_en && (resp_id == WIDTH_P_ID'(P_ID));
  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign push       = id_match && !fifo_full;
  assign req_en     = (state_q == REQ) && (credits_q != '0);
  assign accept     = req_en && tk_en;
  assign emit       = (wleft_q != '0) && arr_rdy;
  // Refill the shift register when it is empty or is giving up its last word
  // this cycle, so consecutive beats stream without a gap.
  assign pop        = !fifo_empty && ((wleft_q == '0) || (emit && (wleft_q == WLW'(1))));
  assign row_last   = (row_q == RW'(nRows - 1));
  assign chn_last   = (chn_q == nchn_q - WC'(1));
  assign col_last   = (col_q == nper_q - WP'(1));
  assign mem_r_addr = base_q + WIDTH_MEM_ADDR'(col_q) * cstr_q
                    + WIDTH_MEM_ADDR'(row_q) * rstr_q + WIDTH_MEM_ADDR'(chn_q);

  assign rd_req_en      = req_en;
  assign rd_req_out     = req_en ? {WIDTH_P_ID'(P_ID), mem_r_addr} : '0;
  assign data_pc2arr    = dout_q;
  assign data_pc2arr_en = dout_en_q;
  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign ovf_err        = ovf_q;

  // Transfer control: config capture, request counters, credits, completion
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    cstr_d    = cstr_q;
    rstr_d    = rstr_q;
    nper_d    = nper_q;
    nchn_d    = nchn_q;
    total_d   = total_q;
    row_d     = row_q;
    chn_d     = chn_q;
    col_d     = col_q;
    credits_d = credits_q;
    rx_cnt_d  = rx_cnt_q;
    done_d    = 1'b0;
    if (state_q != IDLE) begin
      credits_d = credits_q + CW'(pop) - CW'(accept);
      if (push) rx_cnt_d = rx_cnt_q + TW'(1);
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d    = cfg_base;
          cstr_d    = cfg_cstr;
          rstr_d    = cfg_rstr;
          nper_d    = cfg_nper_eff;
          nchn_d    = cfg_nchn_eff;
          total_d   = TW'(nRows) * TW'(cfg_nchn_eff) * TW'(cfg_nper_eff);
          row_d     = '0;
          chn_d     = '0;
          col_d     = '0;
          rx_cnt_d  = '0;
          credits_d = CW'(FIFO_DEPTH);
          state_d   = REQ;
        end
      end
      REQ: begin
        if (accept) begin
          if (row_last) begin
            row_d = '0;
            if (chn_last) begin
              chn_d = '0;
              if (col_last) begin
                col_d   = '0;
                state_d = DRAIN;
              end else begin
                col_d = col_q + WP'(1);
              end
            end else begin
              chn_d = chn_q + WC'(1);
            end
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      DRAIN: begin
        if ((rx_cnt_q >= total_q) && fifo_empty && (wleft_q == '0)) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Response FIFO pointers, serializer shift register and array output
  always_comb begin
    wptr_d    = wptr_q + PW'(push);
    rptr_d    = rptr_q + PW'(pop);
    sreg_d    = sreg_q;
    wleft_d   = wleft_q;
    dout_d    = dout_q;
    dout_en_d = emit;
    ovf_d     = ovf_q | (id_match && fifo_full);
    if (emit) dout_d = sreg_q[WIDTH_BUS-1 -: WIDTH_ARR];
    if (pop) begin
      sreg_d  = fifo_mem_q[rptr_q[AW-1:0]];
      wleft_d = WLW'(R);
    end else if (emit) begin
      sreg_d  = sreg_q << WIDTH_ARR;
      wleft_d = wleft_q - WLW'(1);
    end
  end

  // Beat storage; contents are don't-care once the pointers are reset
  always_ff @(posedge clk_array) begin
    if (push) fifo_mem_q[wptr_q[AW-1:0]] <= resp_data;
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk_array or negedge rst_array) begin
    if (!rst_array) begin
      state_q   <= IDLE;
      base_q    <= '0;
      cstr_q    <= '0;
      rstr_q    <= '0;
      nper_q    <= '0;
      nchn_q    <= '0;
      total_q   <= '0;
      row_q     <= '0;
      chn_q     <= '0;
      col_q     <= '0;
      credits_q <= '0;
      rx_cnt_q  <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      sreg_q    <= '0;
      wleft_q   <= '0;
      dout_q    <= '0;
      dout_en_q <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      cstr_q    <= cstr_d;
      rstr_q    <= rstr_d;
      nper_q    <= nper_d;
      nchn_q    <= nchn_d;
      total_q   <= total_d;
      row_q     <= row_d;
      chn_q     <= chn_d;
      col_q     <= col_d;
      credits_q <= credits_d;
      rx_cnt_q  <= rx_cnt_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      sreg_q    <= sreg_d;
      wleft_q   <= wleft_d;
      dout_q    <= dout_d;
      dout_en_q <= dout_en_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule

// File: tb/tb_pc_rd.sv
// Testbench for pc_rd: table of directed transfers, hand-written credit,
// latency, overflow and abort sequences, then randomized transfers.
module tb_pc_rd;
  localparam int WA    = 16;
  localparam int WB    = 64;
  localparam int R     = WB / WA;
  localparam int PID   = 0;
  localparam int NROWS = 3;
  localparam int FD    = 4;
  localparam int CFGW  = 3*28 + 4 + 11;

  logic            clk = 1'b0;
  logic            rst_n, start, tk_en, rd_req_en, rd_resp_en, arr_rdy;
  logic            data_pc2arr_en, busy, done, ovf_err;
  logic [CFGW-1:0] config_bits;
  logic [33:0]     rd_req_out;
  logic [6+WB-1:0] rd_resp_in;
  logic [WA-1:0]   data_pc2arr;

  always #5 clk = ~clk;

  pc_rd #(
    .WIDTH_ARR(WA), .WIDTH_BUS(WB), .P_ID(PID), .nRows(NROWS),
    .MAX_nPERIOD(16), .MAX_nCHN(2048), .FIFO_DEPTH(FD)
  ) dut (
    .clk_array(clk), .rst_array(rst_n), .start(start), .config_bits(config_bits),
    .tk_en(tk_en), .rd_req_out(rd_req_out), .rd_req_en(rd_req_en),
    .rd_resp_in(rd_resp_in), .rd_resp_en(rd_resp_en), .arr_rdy(arr_rdy),
    .data_pc2arr(data_pc2arr), .data_pc2arr_en(data_pc2arr_en),
    .busy(busy), .done(done), .ovf_err(ovf_err)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [27:0] exp_addr[$];
  logic [15:0] exp_word[$];
  logic [63:0] pend_data[$];
  int          pend_at[$];
  logic [27:0] obs_addr[$];
  logic [15:0] obs_word[$];

  typedef struct {
    logic [27:0]         base, cs, rs;
    int                  np, nc;
    logic [63:0]         data;
    int                  n;
    logic [0:11][27:0]   addr;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [CFGW-1:0] mk_cfg(input logic [27:0] base, cs, rs,
                                             input logic [3:0] np, input logic [10:0] nc);
    return {base, cs, rs, np, nc};
  endfunction

  // One full transfer driven against a memory/array model; the model derives
  // addresses from nested loops and words from slicing each returned beat.
  task automatic run_transfer(input logic [27:0] base, cs, rs, input int np, nc,
                              input logic [63:0] fixed, input int tk_mode, rdy_mode, fpct);
    logic [63:0] d;
    int done_cnt, done_cyc, last_en, n_acc, n_words, nreq, ep, ec;
    bit finished;
    done_cnt = 0; done_cyc = 0; last_en = -100; n_acc = 0; n_words = 0; finished = 0;
    ep = (np == 0) ? 1 : np;
    ec = (nc == 0) ? 1 : nc;
    exp_addr.delete(); exp_word.delete(); pend_data.delete(); pend_at.delete();
    obs_addr.delete(); obs_word.delete();
    for (int c = 0; c < ep; c++)
      for (int ch = 0; ch < ec; ch++)
        for (int r = 0; r < NROWS; r++)
          exp_addr.push_back(28'(base + c*cs + r*rs + ch));
    nreq = exp_addr.size();
    @(negedge clk);
    config_bits = mk_cfg(base, cs, rs, 4'(np), 11'(nc));
    start = 1'b1; tk_en = 1'b0; rd_resp_en = 1'b0; arr_rdy = 1'b0;
    for (int k = 0; k < 3000 && !finished; k++) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (data_pc2arr_en) begin
        n_words++;
        last_en = cyc;
        obs_word.push_back(data_pc2arr);
        if (exp_word.size() > 0) chk("word", data_pc2arr, exp_word.pop_front());
      end
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_cyc = cyc;
          chk("done_after_last_word", cyc - last_en, 1);
        end
      end
      if (done_cnt > 0 && cyc >= done_cyc + 4) finished = 1;
      tk_en = (tk_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      case (rdy_mode)
        0:       arr_rdy = 1'b1;
        1:       arr_rdy = ~arr_rdy;
        default: arr_rdy = 1'($urandom_range(0, 1));
      endcase
      if (rd_req_en && tk_en) begin
        n_acc++;
        obs_addr.push_back(rd_req_out[27:0]);
        if (exp_addr.size() > 0) chk("req_addr", rd_req_out, {6'(PID), exp_addr.pop_front()});
        d = (fixed != 0) ? fixed : {$urandom, $urandom};
        pend_data.push_back(d);
        pend_at.push_back(cyc + int'($urandom_range(1, 3)));
      end
      rd_resp_en = 1'b0;
      if (pend_data.size() > 0 && pend_at[0] <= cyc && $urandom_range(0, 3) != 0) begin
        d = pend_data.pop_front();
        void'(pend_at.pop_front());
        rd_resp_in = {6'(PID), d};
        rd_resp_en = 1'b1;
        for (int i = 0; i < R; i++) exp_word.push_back(d[WB-1-WA*i -: WA]);
      end else if ($urandom_range(0, 99) < fpct) begin
        rd_resp_in = {6'(PID + 1 + int'($urandom_range(0, 5))), $urandom, $urandom};
        rd_resp_en = 1'b1;
      end
    end
    rd_resp_en = 1'b0;
    tk_en = 1'b0;
    chk("done_pulses", done_cnt, 1);
    chk("req_count", n_acc, nreq);
    chk("word_count", n_words, nreq * R);
    chk("busy_after_done", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [33:0] got;
    int n, nw, first_en, last_en;
    rst_n = 1'b0; start = 1'b0; tk_en = 1'b0; arr_rdy = 1'b0;
    rd_resp_en = 1'b0; rd_resp_in = '0; config_bits = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {busy, done, ovf_err, rd_req_en, data_pc2arr_en, data_pc2arr, rd_req_out}, '0);
    rst_n = 1'b1;

    vecs[0] = '{28'h100, 28'h0, 28'h10, 1, 1, 64'h0001_0002_0003_0004, 3,
                {28'h100, 28'h110, 28'h120, {9{28'h0}}}};
    vecs[1] = '{28'h0, 28'h1000, 28'h10, 2, 2, 64'h0, 12,
                {28'h0, 28'h10, 28'h20, 28'h1, 28'h11, 28'h21,
                 28'h1000, 28'h1010, 28'h1020, 28'h1001, 28'h1011, 28'h1021}};
    vecs[2] = '{28'hFFFFFFF, 28'h0, 28'h1, 1, 1, 64'h0, 3,
                {28'hFFFFFFF, 28'h0, 28'h1, {9{28'h0}}}};
    vecs[3] = '{28'h200, 28'h0, 28'h4, 0, 0, 64'h0, 3,
                {28'h200, 28'h204, 28'h208, {9{28'h0}}}};
    vecs[4] = '{28'h50, 28'h100, 28'h0, 2, 2, 64'h0, 12,
                {28'h50, 28'h50, 28'h50, 28'h51, 28'h51, 28'h51,
                 28'h150, 28'h150, 28'h150, 28'h151, 28'h151, 28'h151}};

    for (int v = 0; v < 5; v++) begin
      run_transfer(vecs[v].base, vecs[v].cs, vecs[v].rs, vecs[v].np, vecs[v].nc,
                   vecs[v].data, (v == 0) ? 0 : 1, v % 3, (v % 3 == 1) ? 30 : 0);
      chk("tbl_nreq", obs_addr.size(), vecs[v].n);
      for (int i = 0; i < vecs[v].n && i < obs_addr.size(); i++)
        chk("tbl_addr", obs_addr[i], vecs[v].addr[i]);
      if (vecs[v].data != 0)
        for (int i = 0; i < 4 && i < obs_word.size(); i++)
          chk("basic_word", obs_word[i], i + 1);
    end

    // Credit limit with responses withheld; a start while busy must be ignored
    @(negedge clk);
    config_bits = mk_cfg(28'h300, 28'h0, 28'h10, 4'd1, 11'd3);
    start = 1'b1; tk_en = 1'b1; arr_rdy = 1'b1; rd_resp_en = 1'b0;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      start = (k == 8);
      if (k == 8) config_bits = mk_cfg(28'h900, 28'h0, 28'h40, 4'd2, 11'd2);
      if (rd_req_en && tk_en) n++;
    end
    chk("credit_limit_reqs", n, 4);
    chk("credit_limit_en", rd_req_en, 0);
    chk("busy_in_req", busy, 1);

    // First-word latency from an accepted beat into an empty FIFO
    @(negedge clk);
    tk_en = 1'b0;
    rd_resp_in = {6'(PID), 64'h000A_000B_000C_000D};
    rd_resp_en = 1'b1;
    @(negedge clk);
    rd_resp_en = 1'b0;
    chk("lat_edge1", data_pc2arr_en, 0);
    @(negedge clk);
    chk("lat_edge2", data_pc2arr_en, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("lat_word_en", data_pc2arr_en, 1);
      chk("lat_word", data_pc2arr, 10 + i);
    end

    // The returned credit allows exactly one more request, continuing the old config
    n = 0; got = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      tk_en = 1'b1;
      if (rd_req_en && tk_en) begin
        n++;
        got = rd_req_out;
      end
    end
    chk("credit_return_reqs", n, 1);
    chk("credit_return_addr", got, {6'(PID), 28'h311});

    // Abort mid-transfer
    @(negedge clk);
    tk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {busy, done, ovf_err, rd_req_en, data_pc2arr_en, data_pc2arr, rd_req_out}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done || busy) n++;
    end
    chk("abort_quiet", n, 0);

    // Overflow: array stalled, six beats pushed back to back
    @(negedge clk);
    config_bits = mk_cfg(28'h0, 28'h0, 28'h1, 4'd1, 11'd3);
    start = 1'b1; tk_en = 1'b0; arr_rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 5) chk("ovf_before_6th", ovf_err, 0);
      rd_resp_in = {6'(PID), 16'(4*i), 16'(4*i+1), 16'(4*i+2), 16'(4*i+3)};
      rd_resp_en = 1'b1;
    end
    @(negedge clk);
    rd_resp_en = 1'b0;
    chk("ovf_set", ovf_err, 1);
    repeat (4) @(negedge clk);
    chk("ovf_sticky", ovf_err, 1);
    arr_rdy = 1'b1;
    nw = 0; first_en = -1; last_en = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (data_pc2arr_en) begin
        chk("ovf_drain_word", data_pc2arr, nw);
        nw++;
        if (first_en < 0) first_en = k;
        last_en = k;
      end
    end
    chk("ovf_drain_count", nw, 20);
    chk("no_bubble_span", last_en - first_en, 19);
    chk("ovf_still_set", ovf_err, 1);
    rst_n = 1'b0;
    #1;
    chk("ovf_cleared_by_reset", ovf_err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized transfers with backpressure, token gaps and foreign beats
    for (int t = 0; t < 8; t++)
      run_transfer(28'($urandom), 28'($urandom), 28'($urandom),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   64'h0, 1, int'($urandom_range(0, 2)), 30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
